mac_packet_arbiter: RTL and testbench
=====================================

Name: mac_packet_arbiter

Overview:
- Shares one piped_mac-style accumulator between C_NUM_REQ independent requester streams.
- Arbitrates round-robin at packet granularity (TLAST-delimited dot products) and forwards the granted stream to the MAC.
- Keeps an in-order tag FIFO of granted requesters and routes each 32-bit MAC result back to the requester that issued that packet.

Parameters:
C_DATA_WIDTH, 8, width of each input/weight element (MAC beat = 2*C_DATA_WIDTH)
C_NUM_REQ, 4, number of requesters (2..8)
C_TAG_DEPTH, 2, tag FIFO depth = max packets sent to MAC awaiting result (power of 2)

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset; one clock; reset is asynchronous and active-low
S_AXIS_TDATA  in  C_NUM_REQ*2*C_DATA_WIDTH  per-requester {input,weight}, lane i at [i*2*C_DATA_WIDTH +: 2*C_DATA_WIDTH]
S_AXIS_TUSER  in  C_NUM_REQ*32  per-requester bias, lane i at [i*32 +: 32]
S_AXIS_TLAST  in  C_NUM_REQ  per-requester last beat
S_AXIS_TVALID  in  C_NUM_REQ  per-requester valid
S_AXIS_TREADY  out  C_NUM_REQ  per-requester ready
MD_AXIS_TDATA  out  2*C_DATA_WIDTH  beat to MAC
MD_AXIS_TUSER  out  32  bias to MAC
MD_AXIS_TLAST  out  1  last beat to MAC
MD_AXIS_TVALID  out  1  valid to MAC
MD_AXIS_TID  out  8  granted index, zero-extended
MD_AXIS_TREADY  in  1  MAC ready
SR_AXIS_TDATA  in  32  MAC result
SR_AXIS_TVALID  in  1  MAC result valid
SR_AXIS_TREADY  out  1  result ready to MAC
M_AXIS_TDATA  out  32  result, broadcast to all requesters
M_AXIS_TVALID  out  C_NUM_REQ  one-hot result valid
M_AXIS_TREADY  in  C_NUM_REQ  per-requester result ready
ERR_ORPHAN  out  1  sticky: result offered while tag FIFO empty

Behaviour:
- Reset (async, ARESETN=0):
  - state=IDLE, grant=0, rr_last=C_NUM_REQ-1 so requester 0 wins first.
  - Tag FIFO empty, ERR_ORPHAN=0.
  - All TREADY/TVALID outputs 0. MD_AXIS_TID=0.
- State IDLE:
  - Nothing forwarded; S_AXIS_TREADY=0, MD_AXIS_TVALID=0.
  - Condition: any S_AXIS_TVALID and tag FIFO not full.
  - When met, grant = first valid index scanning rr_last+1, rr_last+2, ... (mod C_NUM_REQ); next state BUSY. Arbitration latency is 1 cycle.
  - If the FIFO is full, stay in IDLE.
- State BUSY:
  - Combinational passthrough of lane grant: MD_AXIS_TDATA/TUSER/TLAST/TVALID = lane grant.
  - S_AXIS_TREADY[grant]=MD_AXIS_TREADY; all other S_AXIS_TREADY=0. MD_AXIS_TID=grant.
  - Grant is locked until a beat with TLAST handshakes (MD_AXIS_TVALID & MD_AXIS_TREADY & MD_AXIS_TLAST).
  - On that beat: push grant to tag FIFO, rr_last<=grant, state<=IDLE.
  - Single-beat packets behave identically (one BUSY cycle).
  - Deasserted TVALID mid-packet holds the grant. No timeout.
- Result path:
  - head = tag FIFO head.
  - M_AXIS_TVALID[head] = SR_AXIS_TVALID & !empty; other lanes 0. M_AXIS_TDATA = SR_AXIS_TDATA.
  - SR_AXIS_TREADY = !empty & M_AXIS_TREADY[head].
  - Pop on result handshake (SR_AXIS_TVALID & SR_AXIS_TREADY). No added latency; purely combinational routing.
- Tag FIFO:
  - Pointers wrap mod C_TAG_DEPTH; occupancy counter 0..C_TAG_DEPTH.
  - Simultaneous push and pop is allowed in any occupancy, including full: count unchanged, pointers both advance.
  - Push when full cannot occur, because no grant is issued while full.
  - Since BUSY cannot be entered while full, a push while full only follows a same-cycle pop.
- ERR_ORPHAN: set when SR_AXIS_TVALID=1 and FIFO empty. SR_AXIS_TREADY stays 0 in that case. Cleared only by reset.
- Fairness: a requester with continuous TVALID waits at most C_NUM_REQ-1 packets.
- Reset mid-packet: MAC-side packet is truncated. Integration must reset the MAC together with this block.

Test Plan:
- Single requester: lane 2 sends 3 beats {1,2},{3,4},{5,6}, bias 10; MAC model returns 54 -> MD_AXIS_TID=2 on all beats; M_AXIS_TVALID=4'b0100 with M_AXIS_TDATA=54; tag FIFO empty afterwards.
- All 4 lanes valid continuously with 2-beat packets -> grant order 0,1,2,3,0; each grant begins exactly 1 cycle after the previous TLAST handshake.
- Back-pressure: MAC result stalled with C_TAG_DEPTH=2 and 2 packets in flight -> stays IDLE with all S_AXIS_TREADY=0. Release one result -> next grant issued the following cycle.
- Simultaneous push/pop with FIFO at 1: TLAST handshake from lane 1 in the same cycle as result pop for lane 0 -> count stays 1; next result goes to lane 1.
- M_AXIS_TREADY[head]=0 for 5 cycles -> SR_AXIS_TREADY=0 and result held stable for those cycles; pop happens on cycle 6.
- SR_AXIS_TVALID=1 with empty FIFO -> ERR_ORPHAN=1 the next cycle and stays set. Async reset mid-packet -> all TVALID/TREADY drop to 0 immediately, and the next grant goes to lane 0.

Source files
------------

// File: rtl/mac_packet_arbiter.sv
// mac_packet_arbiter
//   Shares one accumulating MAC between C_NUM_REQ requester streams. Packets
//   (TLAST-delimited) are granted round-robin and forwarded whole; an in-order
//   tag FIFO remembers who owns each packet so the MAC result can be routed back.
// Ports:
//   ACLK, ARESETN            clock, async active-low reset
//   S_AXIS_*                 per-requester {input,weight} beats, bias, last, valid/ready
//   MD_AXIS_*                granted beat stream to the MAC, TID = granted index
//   SR_AXIS_*                result stream from the MAC
//   M_AXIS_*                 result broadcast, one-hot valid to the owning requester
//   ERR_ORPHAN               sticky flag: MAC offered a result with no packet outstanding
module mac_packet_arbiter #(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_NUM_REQ    = 4,
  parameter int C_TAG_DEPTH  = 2
) (
  input  logic                                ACLK,
  input  logic                                ARESETN,
  input  logic [C_NUM_REQ*2*C_DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic [C_NUM_REQ*32-1:0]             S_AXIS_TUSER,
  input  logic [C_NUM_REQ-1:0]                S_AXIS_TLAST,
  input  logic [C_NUM_REQ-1:0]                S_AXIS_TVALID,
  output logic [C_NUM_REQ-1:0]                S_AXIS_TREADY,
  output logic [2*C_DATA_WIDTH-1:0]           MD_AXIS_TDATA,
  output logic [31:0]                         MD_AXIS_TUSER,
  output logic                                MD_AXIS_TLAST,
  output logic                                MD_AXIS_TVALID,
  output logic [7:0]                          MD_AXIS_TID,
  input  logic                                MD_AXIS_TREADY,
  input  logic [31:0]                         SR_AXIS_TDATA,
  input  logic                                SR_AXIS_TVALID,
  output logic                                SR_AXIS_TREADY,
  output logic [31:0]                         M_AXIS_TDATA,
  output logic [C_NUM_REQ-1:0]                M_AXIS_TVALID,
  input  logic [C_NUM_REQ-1:0]                M_AXIS_TREADY,
  output logic                                ERR_ORPHAN
);

  localparam int          BW = 2*C_DATA_WIDTH;
  localparam int          IW = $clog2(C_NUM_REQ);
  localparam int          PW = (C_TAG_DEPTH > 1) ? $clog2(C_TAG_DEPTH) : 1;
  localparam int          CW = $clog2(C_TAG_DEPTH + 1);
  localparam int unsigned NR = C_NUM_REQ;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] grant, grant_nxt;
  logic [IW-1:0] rr_last, rr_last_nxt;
  logic [IW-1:0] pick;
  logic          pick_ok;
  logic [IW-1:0] tag_mem [C_TAG_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] head;
  logic          empty, full, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(C_TAG_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin scan starting just after the last requester served.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] cand;
    pick    = rr_last;
    pick_ok = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int unsigned i = 1; i <= NR; i++) begin
      idx  = (32'(rr_last) + i) % NR;
      cand = IW'(idx);
      if (!pick_ok && S_AXIS_TVALID[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  // Forward path: lane grant is muxed unconditionally; only VALID/READY are gated.
  assign MD_AXIS_TDATA = S_AXIS_TDATA[grant*BW +: BW];
  assign MD_AXIS_TUSER = S_AXIS_TUSER[grant*32 +: 32];
  assign MD_AXIS_TLAST = S_AXIS_TLAST[grant];
  assign MD_AXIS_TID   = 8'(grant);

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    rr_last_nxt    = rr_last;
    push           = 1'b0;
    S_AXIS_TREADY  = '0;
    MD_AXIS_TVALID = 1'b0;
    case (state)
      IDLE: begin
        if (pick_ok && !full) begin
          grant_nxt = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        MD_AXIS_TVALID       = S_AXIS_TVALID[grant];
        S_AXIS_TREADY[grant] = MD_AXIS_TREADY;
        if (MD_AXIS_TVALID && MD_AXIS_TREADY && MD_AXIS_TLAST) begin
          push        = 1'b1;
          rr_last_nxt = grant;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result path: purely combinational routing to the owner at the FIFO head.
  assign empty          = (count == '0);
  assign full           = (count == CW'(C_TAG_DEPTH));
  assign head           = tag_mem[rd_ptr];
  assign SR_AXIS_TREADY = !empty && M_AXIS_TREADY[head];
  assign pop            = SR_AXIS_TVALID && SR_AXIS_TREADY;
  assign M_AXIS_TDATA   = SR_AXIS_TDATA;

  always_comb begin
    M_AXIS_TVALID       = '0;
    M_AXIS_TVALID[head] = SR_AXIS_TVALID && !empty;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state      <= IDLE;
      grant      <= '0;
      rr_last    <= IW'(C_NUM_REQ - 1);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ERR_ORPHAN <= 1'b0;
      for (int unsigned k = 0; k < C_TAG_DEPTH; k++) tag_mem[k] <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_last <= rr_last_nxt;
      if (push) begin
        tag_mem[wr_ptr] <= grant;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      // Push while full only happens alongside a pop, so count never overflows.
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (SR_AXIS_TVALID && empty) ERR_ORPHAN <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_packet_arbiter.sv
// tb_mac_packet_arbiter
//   Directed bench for mac_packet_arbiter (4 requesters, tag depth 2). The bench
//   plays all requesters and the MAC; expected values are hand-derived constants.
module tb_mac_packet_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TD = 2;

  logic               ACLK = 1'b0;
  logic               ARESETN = 1'b0;
  logic [NR*2*DW-1:0] s_tdata;
  logic [NR*32-1:0]   s_tuser;
  logic [NR-1:0]      s_tlast, s_tvalid, s_tready;
  logic [2*DW-1:0]    md_tdata;
  logic [31:0]        md_tuser;
  logic               md_tlast, md_tvalid, md_tready;
  logic [7:0]         md_tid;
  logic [31:0]        sr_tdata;
  logic               sr_tvalid, sr_tready;
  logic [31:0]        m_tdata;
  logic [NR-1:0]      m_tvalid, m_tready;
  logic               err;

  int checks   = 0;
  int failures = 0;

  always #5 ACLK = ~ACLK;

  mac_packet_arbiter #(
    .C_DATA_WIDTH(DW),
    .C_NUM_REQ   (NR),
    .C_TAG_DEPTH (TD)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TUSER  (s_tuser),
    .S_AXIS_TLAST  (s_tlast),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .MD_AXIS_TDATA (md_tdata),
    .MD_AXIS_TUSER (md_tuser),
    .MD_AXIS_TLAST (md_tlast),
    .MD_AXIS_TVALID(md_tvalid),
    .MD_AXIS_TID   (md_tid),
    .MD_AXIS_TREADY(md_tready),
    .SR_AXIS_TDATA (sr_tdata),
    .SR_AXIS_TVALID(sr_tvalid),
    .SR_AXIS_TREADY(sr_tready),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .ERR_ORPHAN    (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic lane(input int i, input logic v, input logic l,
                      input logic [7:0] a, input logic [7:0] w, input logic [31:0] b);
    s_tvalid[i]          = v;
    s_tlast[i]           = l;
    s_tdata[i*16 +: 16]  = {a, w};
    s_tuser[i*32 +: 32]  = b;
  endtask

  // Pulse reset between clock edges; leaves time short of the next posedge.
  task automatic do_reset();
    s_tvalid  = '0;
    s_tlast   = '0;
    sr_tvalid = 1'b0;
    m_tready  = '1;
    ARESETN   = 1'b0;
    #2;
    ARESETN   = 1'b1;
  endtask

  initial begin
    int g, prev_g, exp_sum;
    s_tdata   = '0;
    s_tuser   = '0;
    s_tlast   = '0;
    s_tvalid  = '0;
    md_tready = 1'b1;
    sr_tdata  = '0;
    sr_tvalid = 1'b0;
    m_tready  = '1;
    g         = 0;
    prev_g    = 0;

    // Reset state
    #1;
    check_eq("rst_s_tready", s_tready, 0);
    check_eq("rst_md_tvalid", md_tvalid, 0);
    check_eq("rst_md_tid", md_tid, 0);
    check_eq("rst_m_tvalid", m_tvalid, 0);
    check_eq("rst_sr_tready", sr_tready, 0);
    check_eq("rst_err", err, 0);
    #2;
    ARESETN = 1'b1;
    step();

    // Single requester: lane 2, three beats, bias 10
    exp_sum = 1*2 + 3*4 + 5*6 + 10;
    lane(2, 1, 0, 8'd1, 8'd2, 32'd10);
    #1;
    check_eq("t1_idle_tready", s_tready, 0);
    check_eq("t1_idle_tvalid", md_tvalid, 0);
    step();
    #1;
    check_eq("t1_b0_tid", md_tid, 2);
    check_eq("t1_b0_tvalid", md_tvalid, 1);
    check_eq("t1_b0_tdata", md_tdata, 16'h0102);
    check_eq("t1_b0_tuser", md_tuser, 10);
    check_eq("t1_b0_tready", s_tready, 4'b0100);
    check_eq("t1_b0_tlast", md_tlast, 0);
    step();
    lane(2, 1, 0, 8'd3, 8'd4, 32'd10);
    #1;
    check_eq("t1_b1_tid", md_tid, 2);
    check_eq("t1_b1_tdata", md_tdata, 16'h0304);
    step();
    lane(2, 1, 1, 8'd5, 8'd6, 32'd10);
    #1;
    check_eq("t1_b2_tid", md_tid, 2);
    check_eq("t1_b2_tlast", md_tlast, 1);
    step();
    lane(2, 0, 0, 8'd0, 8'd0, 32'd0);
    sr_tdata  = 32'(exp_sum);
    sr_tvalid = 1'b1;
    #1;
    check_eq("t1_res_tvalid", m_tvalid, 4'b0100);
    check_eq("t1_res_tdata", m_tdata, 54);
    check_eq("t1_res_ready", sr_tready, 1);
    check_eq("t1_idle_after", md_tvalid, 0);
    step();
    sr_tvalid = 1'b0;
    #1;
    check_eq("t1_fifo_empty", sr_tready, 0);

    // All lanes valid, 2-beat packets: grant order 0,1,2,3,0
    do_reset();
    for (int i = 0; i < NR; i++) lane(i, 1, 0, 8'(i + 1), 8'h10, 32'(i * 100));
    for (int p = 0; p < 5; p++) begin
      g = p % NR;
      if (p > 0) begin
        sr_tvalid = 1'b1;
        sr_tdata  = 32'(1000 + p);
      end
      #1;
      check_eq("t2_idle_tready", s_tready, 0);
      if (p > 0) check_eq("t2_res_route", m_tvalid, 32'(1) << prev_g);
      step();
      sr_tvalid = 1'b0;
      #1;
      check_eq("t2_grant_tid", md_tid, g);
      check_eq("t2_grant_tready", s_tready, 32'(1) << g);
      check_eq("t2_b0_tdata", md_tdata, {8'(g + 1), 8'h10});
      step();
      lane(g, 1, 1, 8'(g + 1), 8'h20, 32'(g * 100));
      #1;
      check_eq("t2_b1_tlast", md_tlast, 1);
      check_eq("t2_b1_tid", md_tid, g);
      step();
      lane(g, 1, 0, 8'(g + 1), 8'h10, 32'(g * 100));
      prev_g = g;
    end
    sr_tvalid = 1'b1;
    #1;
    check_eq("t2_last_route", m_tvalid, 4'b0001);
    step();
    sr_tvalid = 1'b0;
    #1;
    check_eq("t2_fifo_empty", sr_tready, 0);

    // Back-pressure: two packets in flight fill the tag FIFO
    do_reset();
    lane(0, 1, 1, 8'd1, 8'd1, 32'd0);
    lane(1, 1, 1, 8'd2, 8'd2, 32'd0);
    lane(2, 1, 1, 8'd3, 8'd3, 32'd0);
    #1;
    step();
    #1;
    check_eq("t3_g0", md_tid, 0);
    step();
    lane(0, 0, 0, 8'd0, 8'd0, 32'd0);
    #1;
    step();
    #1;
    check_eq("t3_g1", md_tid, 1);
    step();
    lane(1, 0, 0, 8'd0, 8'd0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("t3_stall_tready", s_tready, 0);
      check_eq("t3_stall_tvalid", md_tvalid, 0);
      step();
    end
    sr_tvalid = 1'b1;
    sr_tdata  = 32'd77;
    #1;
    check_eq("t3_rel_route", m_tvalid, 4'b0001);
    check_eq("t3_rel_ready", sr_tready, 1);
    check_eq("t3_rel_tready", s_tready, 0);
    step();
    sr_tvalid = 1'b0;
    #1;
    check_eq("t3_arb_tready", s_tready, 0);
    step();
    #1;
    check_eq("t3_g2", md_tid, 2);
    check_eq("t3_g2_tready", s_tready, 4'b0100);
    step();
    lane(2, 0, 0, 8'd0, 8'd0, 32'd0);
    sr_tvalid = 1'b1;
    #1;
    check_eq("t3_drain1", m_tvalid, 4'b0010);
    step();
    #1;
    check_eq("t3_drain2", m_tvalid, 4'b0100);
    step();
    sr_tvalid = 1'b0;

    // Simultaneous push and pop with one packet outstanding
    do_reset();
    lane(0, 1, 1, 8'd1, 8'd1, 32'd0);
    #1;
    step();
    step();
    lane(0, 0, 0, 8'd0, 8'd0, 32'd0);
    lane(1, 1, 0, 8'd2, 8'd2, 32'd0);
    #1;
    step();
    #1;
    check_eq("t4_g1", md_tid, 1);
    step();
    lane(1, 1, 1, 8'd2, 8'd3, 32'd0);
    sr_tvalid = 1'b1;
    sr_tdata  = 32'd111;
    #1;
    check_eq("t4_pop_route", m_tvalid, 4'b0001);
    check_eq("t4_pop_ready", sr_tready, 1);
    check_eq("t4_push_last", md_tlast & md_tvalid, 1);
    step();
    lane(1, 0, 0, 8'd0, 8'd0, 32'd0);
    sr_tdata = 32'd222;
    #1;
    check_eq("t4_next_head", m_tvalid, 4'b0010);
    check_eq("t4_next_data", m_tdata, 222);
    step();
    sr_tvalid = 1'b0;
    #1;
    check_eq("t4_count_one", sr_tready, 0);

    // Result held while owner not ready for 5 cycles
    lane(2, 1, 1, 8'd4, 8'd4, 32'd0);
    #1;
    step();
    step();
    lane(2, 0, 0, 8'd0, 8'd0, 32'd0);
    sr_tvalid = 1'b1;
    sr_tdata  = 32'hABCD;
    m_tready  = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("t5_hold_ready", sr_tready, 0);
      check_eq("t5_hold_route", m_tvalid, 4'b0100);
      check_eq("t5_hold_data", m_tdata, 32'hABCD);
      step();
    end
    m_tready = '1;
    #1;
    check_eq("t5_c6_ready", sr_tready, 1);
    step();
    sr_tvalid = 1'b0;
    #1;
    check_eq("t5_popped", sr_tready, 0);

    // Orphan result with empty FIFO
    check_eq("t6_err_pre", err, 0);
    sr_tvalid = 1'b1;
    #1;
    check_eq("t6_orphan_ready", sr_tready, 0);
    check_eq("t6_orphan_route", m_tvalid, 0);
    step();
    sr_tvalid = 1'b0;
    #1;
    check_eq("t6_err_set", err, 1);
    step();
    step();
    #1;
    check_eq("t6_err_sticky", err, 1);

    // Async reset mid-packet
    lane(3, 1, 0, 8'd5, 8'd5, 32'd0);
    #1;
    step();
    #1;
    check_eq("t7_busy_tready", s_tready, 4'b1000);
    step();
    #2;
    ARESETN = 1'b0;
    #1;
    check_eq("t7_rst_tready", s_tready, 0);
    check_eq("t7_rst_tvalid", md_tvalid, 0);
    check_eq("t7_rst_tid", md_tid, 0);
    check_eq("t7_rst_err", err, 0);
    check_eq("t7_rst_m_tvalid", m_tvalid, 0);
    ARESETN = 1'b1;
    lane(0, 1, 1, 8'd6, 8'd6, 32'd0);
    #1;
    step();
    #1;
    check_eq("t7_first_grant", md_tid, 0);
    check_eq("t7_first_tready", s_tready, 4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
